// File: rtl/opcode_sequencer.sv
// opcode_sequencer: program buffer that replays a loaded opcode program to the core array
// and packs the serial valid_bit/output_bit result stream into words.
module opcode_sequencer #(
    parameter int DEPTH        = 16,
    parameter int OPCODE_WIDTH = 16,
    parameter int LOOP_WIDTH   = 8,
    parameter int RESULT_WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wr_valid,
    output logic                    wr_ready,
    input  logic [OPCODE_WIDTH-1:0] wr_opcode,
    input  logic                    clear,
    input  logic                    start,
    input  logic                    abort,
    input  logic [LOOP_WIDTH-1:0]   loop_count,
    output logic                    busy,
    output logic                    done,
    output logic [OPCODE_WIDTH-1:0] opcode_out,
    output logic                    execute_out,
    input  logic                    valid_bit_in,
    input  logic                    output_bit_in,
    output logic                    result_valid,
    output logic [RESULT_WIDTH-1:0] result_word
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(RESULT_WIDTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0] ONE = (AW+1)'(1);
    localparam logic [CW-1:0] LAST = CW'(RESULT_WIDTH - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t                  r_state;
    logic [OPCODE_WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]             r_wr_ptr;
    logic [AW:0]             r_rd_ptr;
    logic [LOOP_WIDTH-1:0]   r_iter;
    logic [LOOP_WIDTH-1:0]   r_loop;
    logic                    r_wr_ready;
    logic                    r_busy;
    logic                    r_done;
    logic [OPCODE_WIDTH-1:0] r_opcode;
    logic                    r_exec;
    logic [CW-1:0]           r_bit_cnt;
    logic [RESULT_WIDTH-1:0] r_shreg;
    logic [RESULT_WIDTH-1:0] r_word;
    logic                    r_res_valid;

    logic                    w_idle;
    logic                    w_wr_fire;
    logic                    w_start_ok;
    logic [AW:0]             w_wr_ptr_nxt;
    logic [RESULT_WIDTH-1:0] w_shift;

    always_comb begin
        w_idle       = r_state == S_IDLE;
        w_wr_fire    = w_idle && wr_valid && r_wr_ptr != FULL && !clear;
        w_start_ok   = w_idle && start && !clear && r_wr_ptr != '0;
        w_wr_ptr_nxt = clear ? '0 : w_wr_fire ? r_wr_ptr + ONE : r_wr_ptr;
        w_shift      = {r_shreg[RESULT_WIDTH-2:0], output_bit_in};
    end

    always_ff @(posedge clk) begin
        if (w_wr_fire)
            r_mem[r_wr_ptr[AW-1:0]] <= wr_opcode;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_iter     <= '0;
            r_loop     <= '0;
            r_wr_ready <= 1'b1;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_opcode   <= '0;
            r_exec     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_wr_ptr <= w_wr_ptr_nxt;
                    if (w_start_ok) begin
                        r_state    <= S_RUN;
                        r_loop     <= loop_count;
                        r_iter     <= '0;
                        r_opcode   <= r_mem[0];
                        r_exec     <= 1'b1;
                        r_rd_ptr   <= ONE;
                        r_busy     <= 1'b1;
                        r_wr_ready <= 1'b0;
                    end else begin
                        r_wr_ready <= w_wr_ptr_nxt != FULL;
                    end
                end
                S_RUN: begin
                    if (abort) begin
                        r_state    <= S_IDLE;
                        r_exec     <= 1'b0;
                        r_busy     <= 1'b0;
                        r_wr_ready <= r_wr_ptr != FULL;
                    end else if (r_rd_ptr == r_wr_ptr) begin
                        // last entry is on opcode_out now: finish or wrap with no gap
                        if (r_iter == r_loop) begin
                            r_state <= S_DONE;
                            r_exec  <= 1'b0;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_opcode <= r_mem[0];
                            r_rd_ptr <= ONE;
                            r_iter   <= r_iter + 1'b1;
                        end
                    end else begin
                        r_opcode <= r_mem[r_rd_ptr[AW-1:0]];
                        r_rd_ptr <= r_rd_ptr + ONE;
                    end
                end
                S_DONE: begin
                    r_state    <= S_IDLE;
                    r_wr_ready <= r_wr_ptr != FULL;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bit_cnt   <= '0;
            r_shreg     <= '0;
            r_word      <= '0;
            r_res_valid <= 1'b0;
        end else begin
            r_res_valid <= 1'b0;
            if (w_start_ok) begin
                r_bit_cnt <= '0;
            end else if (valid_bit_in) begin
                r_shreg <= w_shift;
                if (r_bit_cnt == LAST) begin
                    r_bit_cnt   <= '0;
                    r_word      <= w_shift;
                    r_res_valid <= 1'b1;
                end else begin
                    r_bit_cnt <= r_bit_cnt + 1'b1;
                end
            end
        end
    end

    assign wr_ready     = r_wr_ready;
    assign busy         = r_busy;
    assign done         = r_done;
    assign opcode_out   = r_opcode;
    assign execute_out  = r_exec;
    assign result_valid = r_res_valid;
    assign result_word  = r_word;
endmodule

// File: tb/tb_opcode_sequencer.sv
// tb_opcode_sequencer: scoreboard bench; expected opcodes/results are queued when
// stimulus is driven and popped when execute_out/result_valid appear.
module tb_opcode_sequencer;
    localparam int DEPTH = 16;

    logic        clk = 1'b0, rst = 1'b1;
    logic        wr_valid = 1'b0, clear = 1'b0, start = 1'b0, abort = 1'b0;
    logic        valid_bit_in = 1'b0, output_bit_in = 1'b0;
    logic [15:0] wr_opcode = '0;
    logic [7:0]  loop_count = '0;
    logic        wr_ready, busy, done, execute_out, result_valid;
    logic [15:0] opcode_out;
    logic [7:0]  result_word;

    int          n_tests = 0, n_fail = 0, n_done = 0, n_prog = 0;
    logic [15:0] prog [DEPTH];
    logic [15:0] exp_op [$];
    logic [7:0]  exp_res [$];

    opcode_sequencer #(.DEPTH(16), .OPCODE_WIDTH(16), .LOOP_WIDTH(8), .RESULT_WIDTH(8)) dut (
        .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_opcode(wr_opcode),
        .clear(clear), .start(start), .abort(abort), .loop_count(loop_count), .busy(busy),
        .done(done), .opcode_out(opcode_out), .execute_out(execute_out),
        .valid_bit_in(valid_bit_in), .output_bit_in(output_bit_in),
        .result_valid(result_valid), .result_word(result_word)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (execute_out) begin
                if (exp_op.size() == 0) check("exec_extra", 1, 0);
                else check("opcode", opcode_out, exp_op.pop_front());
            end
            if (result_valid) begin
                if (exp_res.size() == 0) check("result_extra", 1, 0);
                else check("result_word", result_word, exp_res.pop_front());
            end
            if (done) n_done++;
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [15:0] op);
        check("wr_ready", wr_ready, n_prog < DEPTH);
        if (n_prog < DEPTH) begin
            prog[n_prog] = op;
            n_prog++;
        end
        wr_valid = 1'b1;
        wr_opcode = op;
        tick;
        wr_valid = 1'b0;
    endtask

    task automatic do_clear;
        clear = 1'b1;
        tick;
        clear = 1'b0;
        n_prog = 0;
    endtask

    task automatic run(input logic [7:0] lc);
        int cyc, d0, total;
        total = n_prog * (int'(lc) + 1);
        for (int p = 0; p <= int'(lc); p++)
            for (int i = 0; i < n_prog; i++) exp_op.push_back(prog[i]);
        d0 = n_done;
        loop_count = lc;
        start = 1'b1;
        tick;
        start = 1'b0;
        check("busy_run", busy, 1);
        cyc = 0;
        while (!done && cyc < 5000) begin
            tick;
            cyc++;
        end
        check("run_len", cyc, total);
        check("exec_at_done", execute_out, 0);
        tick;
        check("done_pulses", n_done - d0, 1);
        check("busy_after", busy, 0);
        check("done_after", done, 0);
        check("queue_drained", exp_op.size(), 0);
    endtask

    task automatic send_bits(input logic [7:0] w, input bit gaps);
        for (int i = 7; i >= 0; i--) begin
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    valid_bit_in = 1'b0;
                    output_bit_in = 1'($urandom);
                    tick;
                end
            end
            valid_bit_in = 1'b1;
            output_bit_in = w[i];
            tick;
        end
        valid_bit_in = 1'b0;
    endtask

    initial begin
        int d0;
        repeat (2) tick;
        rst = 1'b0;
        tick;
        check("rst_wr_ready", wr_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_exec", execute_out, 0);
        check("rst_done", done, 0);
        check("rst_opcode", opcode_out, 0);
        check("rst_rvalid", result_valid, 0);
        check("rst_rword", result_word, 0);

        wr(16'h1234); wr(16'hABCD); wr(16'h0F0F);
        run(8'd0);
        run(8'd2);
        run(8'd255);

        do_clear;
        wr(16'h1111); wr(16'h2222); wr(16'h3333); wr(16'h4444);
        exp_op.push_back(prog[0]);
        exp_op.push_back(prog[1]);
        d0 = n_done;
        start = 1'b1;
        tick;
        start = 1'b0;
        tick;
        abort = 1'b1;
        tick;
        abort = 1'b0;
        check("abort_exec", execute_out, 0);
        check("abort_busy", busy, 0);
        repeat (3) tick;
        check("abort_no_done", n_done - d0, 0);
        check("abort_queue", exp_op.size(), 0);
        check("abort_wr_ready", wr_ready, 1);
        run(8'd1);

        clear = 1'b1;
        start = 1'b1;
        tick;
        clear = 1'b0;
        start = 1'b0;
        n_prog = 0;
        check("clr_start_busy", busy, 0);
        start = 1'b1;
        tick;
        start = 1'b0;
        check("empty_start_busy", busy, 0);
        tick;
        check("empty_start_exec", execute_out, 0);

        for (int i = 0; i < 17; i++) wr(16'hC000 + 16'(i));
        check("full_wr_ready", wr_ready, 0);
        run(8'd0);

        exp_res.push_back(8'hB2);
        send_bits(8'hB2, 1'b0);
        tick;
        check("res_drained", exp_res.size(), 0);
        exp_res.push_back(8'hB2);
        send_bits(8'hB2, 1'b1);
        tick;
        check("res_gap_drained", exp_res.size(), 0);
        repeat (3) tick;
        check("res_hold", result_word, 8'hB2);
        for (int i = 0; i < 3; i++) begin
            valid_bit_in = 1'b1;
            output_bit_in = 1'b1;
            tick;
        end
        valid_bit_in = 1'b0;
        run(8'd0);
        exp_res.push_back(8'h3C);
        send_bits(8'h3C, 1'b1);
        tick;
        check("res_partial_drop", exp_res.size(), 0);

        for (int i = 0; i < n_prog; i++) exp_op.push_back(prog[i]);
        loop_count = 8'd0;
        start = 1'b1;
        tick;
        start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            valid_bit_in = 1'b1;
            output_bit_in = 1'($urandom);
            tick;
        end
        valid_bit_in = 1'b0;
        check("rv_before_rst", result_valid, 1);
        check("q_before_rst", exp_op.size(), 8);
        rst = 1'b1;
        #1;
        check("arst_exec", execute_out, 0);
        check("arst_busy", busy, 0);
        check("arst_done", done, 0);
        check("arst_rvalid", result_valid, 0);
        check("arst_wr_ready", wr_ready, 1);
        exp_op.delete();
        n_prog = 0;
        tick;
        rst = 1'b0;
        tick;
        check("post_rst_wr_ready", wr_ready, 1);
        start = 1'b1;
        tick;
        start = 1'b0;
        check("post_rst_busy", busy, 0);
        tick;
        check("post_rst_exec", execute_out, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
